// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch buffer and the fetch stage.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam int          ADDR_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer holding {pc, instr} entries.
// Flush empties it in one edge; storage itself is never reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fetch_entry_t  mem_q [DEPTH];

    logic do_pop;
    logic do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_pop) rptr_d = ptr_inc(rptr_q);
            if (do_push) wptr_d = ptr_inc(wptr_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: pc register, imem request and redirect control.
// Fetched words are queued in a small buffer ahead of decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus4
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pop;
    logic              push;
    logic              full;
    logic              empty;
    fetch_entry_t      wentry;
    fetch_entry_t      head;

    assign imem_addr = pc_q;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && (!full || pop);
    assign wentry    = '{pc: pc_q, instr: imem_rdata};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wentry),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign out_valid    = !empty;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus4 = head.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a queue model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    logic        w_rst_n;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_plus4;
    logic        w_redir;
    logic [31:0] w_rpc;
    logic        w_ready;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int DEPTH = 2;

    logic [31:0] m_pc;
    logic [63:0] m_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hE000_0000 + (a >> 2);
    endfunction

    assign imem_rdata = rom(imem_addr);
    assign w_rdata    = rom(w_addr);
    assign w_redir    = 1'b0;
    assign w_rpc      = 32'h0;
    assign w_ready    = 1'b1;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (3)
    ) dut_w (
        .clk            (clk),
        .rst_n          (w_rst_n),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (w_redir),
        .redirect_pc    (w_rpc),
        .out_valid      (w_valid),
        .out_ready      (w_ready),
        .out_instr      (w_instr),
        .out_pc         (w_pc),
        .out_pc_plus4   (w_plus4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: a fetch queue of {pc,instr} fed by a free-running pc.
    task automatic model_step();
        logic pop;
        if (!rst_n) begin
            m_pc = 32'h0;
            m_q.delete();
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            pop = (m_q.size() > 0) && out_ready;
            if (pop) void'(m_q.pop_front());
            if (m_q.size() < DEPTH) begin
                m_q.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        logic [63:0] h;
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            h = m_q[0];
            check("out_pc", out_pc, h[63:32]);
            check("out_instr", out_instr, h[31:0]);
            check("out_pc_plus4", out_pc_plus4, h[63:32] + 32'd4);
        end
    endtask

    task automatic step(input logic r, input logic rv,
                        input logic [31:0] rp, input logic rdy);
        rst_n          = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        w_rst_n = 1'b0;
        m_pc    = 32'h0;

        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check("stream_pc", out_pc, 32'(i * 4));
            check("stream_instr", out_instr, 32'hE000_0000 + 32'(i));
        end

        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_addr", imem_addr, 32'h8);
        check("stall_pc", out_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_hold_addr", imem_addr, 32'h8);
        check("stall_hold_pc", out_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("full_pop_pc", out_pc, 32'h4);
        check("full_pop_addr", imem_addr, 32'hC);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("full_pop_pc2", out_pc, 32'h8);

        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0043, 1'b0);
        check("redir_valid", {31'b0, out_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("redir_lat_pc", out_pc, 32'h40);

        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("midrst_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_addr", imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("midrst_pc", out_pc, 32'h0);

        w_rst_n = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
        check("wrap_rst_valid", {31'b0, w_valid}, 32'h0);
        w_rst_n = 1'b1;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", w_plus4, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_pc2", w_pc, 32'h0);
        check("wrap_instr2", w_instr, 32'hE000_0000);

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom(),
                 $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
